// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: memory bus, decoder and execute-stage signals for the fetch sequencer
//   bus_*   : byte read port (req/addr out, ack/rdata in from the master's view)
//   dec_*   : registered bytes to the decoder and its prefix/immediate answers
//   instr_* : assembled instruction with valid/ready handshake to execute
interface fetch_sequencer_if;
    logic        bus_req;
    logic [15:0] bus_addr;
    logic        bus_ack;
    logic [7:0]  bus_rdata;
    logic [7:0]  dec_opcode;
    logic [7:0]  dec_opext;
    logic        dec_need_opext;
    logic        dec_need_imm;
    logic        dec_imm_size;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  instr_opcode;
    logic [7:0]  instr_opext;
    logic [15:0] instr_imm;
    logic [2:0]  instr_len;
    logic [15:0] instr_pc;
    modport master (
        output bus_req, bus_addr, dec_opcode, dec_opext,
        output instr_valid, instr_opcode, instr_opext, instr_imm, instr_len, instr_pc,
        input  bus_ack, bus_rdata, dec_need_opext, dec_need_imm, dec_imm_size, instr_ready
    );
    modport slave (
        input  bus_req, bus_addr, dec_opcode, dec_opext,
        input  instr_valid, instr_opcode, instr_opext, instr_imm, instr_len, instr_pc,
        output bus_ack, bus_rdata, dec_need_opext, dec_need_imm, dec_imm_size, instr_ready
    );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: S1C88 instruction-fetch sequencer assembling opcode/opext/immediate bytes
//   clk, rst         : clock, asynchronous active-high reset
//   i_pc_load        : redirect strobe, wins in every state
//   i_pc_load_value  : redirect target
//   o_pc             : current fetch PC
//   io               : bus, decoder and instruction handshake (master side)
module fetch_sequencer #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_pc_load,
    input  logic [15:0]         i_pc_load_value,
    output logic [15:0]         o_pc,
    fetch_sequencer_if.master   io
);
    typedef enum logic [2:0] {
        IDLE, FETCH_OP, EVAL, FETCH_EXT, FETCH_IMM0, FETCH_IMM1, ISSUE
    } state_t;
    state_t      r_state;
    state_t      w_nxt;
    logic [15:0] r_pc;
    logic [15:0] r_ipc;
    logic [15:0] r_imm;
    logic [7:0]  r_opcode;
    logic [7:0]  r_opext;
    logic [2:0]  r_len;
    logic        r_ext_done;
    logic        r_bus_req;
    logic        r_valid;
    logic        w_ack;
    assign w_ack = r_bus_req && io.bus_ack;
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            IDLE:       w_nxt = FETCH_OP;
            FETCH_OP:   w_nxt = w_ack ? EVAL : FETCH_OP;
            EVAL:       w_nxt = (io.dec_need_opext && !r_ext_done) ? FETCH_EXT :
                                io.dec_need_imm ? FETCH_IMM0 : ISSUE;
            FETCH_EXT:  w_nxt = w_ack ? EVAL : FETCH_EXT;
            FETCH_IMM0: w_nxt = w_ack ? (io.dec_imm_size ? FETCH_IMM1 : ISSUE) : FETCH_IMM0;
            FETCH_IMM1: w_nxt = w_ack ? ISSUE : FETCH_IMM1;
            ISSUE:      w_nxt = io.instr_ready ? FETCH_OP : ISSUE;
            default:    w_nxt = IDLE;
        endcase
        if (i_pc_load)
            w_nxt = FETCH_OP;
    end
    // bus_req and instr_valid are registered from the next state so no input reaches an output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_ipc      <= '0;
            r_imm      <= '0;
            r_opcode   <= '0;
            r_opext    <= '0;
            r_len      <= '0;
            r_ext_done <= 1'b0;
            r_bus_req  <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_state   <= w_nxt;
            r_bus_req <= w_nxt inside {FETCH_OP, FETCH_EXT, FETCH_IMM0, FETCH_IMM1};
            r_valid   <= w_nxt == ISSUE;
            if (i_pc_load) begin
                r_pc <= i_pc_load_value;
            end else if (w_ack) begin
                r_pc  <= r_pc + 16'd1;
                r_len <= r_state == FETCH_OP ? 3'd1 : r_len + 3'd1;
                case (r_state)
                    FETCH_OP: begin
                        r_opcode   <= io.bus_rdata;
                        r_opext    <= '0;
                        r_imm      <= '0;
                        r_ext_done <= 1'b0;
                        r_ipc      <= r_pc;
                    end
                    FETCH_EXT: begin
                        r_opext    <= io.bus_rdata;
                        r_ext_done <= 1'b1;
                    end
                    FETCH_IMM0: r_imm[7:0]  <= io.bus_rdata;
                    FETCH_IMM1: r_imm[15:8] <= io.bus_rdata;
                    default: ;
                endcase
            end
        end
    end
    assign o_pc            = r_pc;
    assign io.bus_req      = r_bus_req;
    assign io.bus_addr     = r_pc;
    assign io.dec_opcode   = r_opcode;
    assign io.dec_opext    = r_opext;
    assign io.instr_valid  = r_valid;
    assign io.instr_opcode = r_opcode;
    assign io.instr_opext  = r_opext;
    assign io.instr_imm    = r_imm;
    assign io.instr_len    = r_len;
    assign io.instr_pc     = r_ipc;
endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch sequencer for the S1C88 core. Reads instruction bytes from the memory bus at the program counter and drives the registered opcode and extension bytes into the instruction decoder. It then uses the decoder's need_opext/need_imm/imm_size answers to fetch exactly the right number of further bytes. The assembled instruction (opcode, opext, 16-bit immediate, length, start PC) goes to the execute stage through a valid/ready handshake. Branch redirects enter through a PC-load port.

## Interface
- RESET_PC, 16'h0000, PC value loaded by reset; first fetch address.
- clk  in  1  core clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- pc_load  in  1  redirect strobe; highest priority in every state.
- pc_load_value  in  16  new PC when pc_load=1.
- bus_req  out  1  read request; address held stable while high.
- bus_addr  out  16  read address (= pc).
- bus_ack  in  1  read complete this cycle; valid only while bus_req=1.
- bus_rdata  in  8  read data, sampled when bus_req&&bus_ack.
- dec_opcode  out  8  registered opcode, to decoder.
- dec_opext  out  8  registered extension byte, to decoder (0 until fetched).
- dec_need_opext  in  1  decoder: opcode is a CE/CF prefix.
- dec_need_imm  in  1  decoder: instruction carries immediate bytes.
- dec_imm_size  in  1  decoder: 0 = one imm byte, 1 = two.
- instr_valid  out  1  assembled instruction available.
- instr_ready  in  1  execute stage accepts; transfer when valid&&ready.
- instr_opcode  out  8  opcode byte.
- instr_opext  out  8  extension byte, 0 if none.
- instr_imm  out  16  immediate, little-endian; upper/whole zero if absent.
- instr_len  out  3  total bytes, 1..4.
- instr_pc  out  16  address of the opcode byte.
- pc  out  16  current fetch PC.

## Operation
- States: IDLE, FETCH_OP, EVAL, FETCH_EXT, FETCH_IMM0, FETCH_IMM1, ISSUE.
- Reset: state IDLE, pc=RESET_PC, opcode/opext/imm/instr_pc=0, len=0, ext_done=0, instr_valid=0, bus_req=0.
- IDLE: bus_req=0; next state FETCH_OP unconditionally.
- FETCH_OP: bus_req=1, bus_addr=pc. On ack, the following updates happen:
  - opcode<=rdata
  - opext<=0, imm<=0, ext_done<=0
  - instr_pc<=pc, pc<=pc+1, len<=1
  - next state EVAL.
- EVAL (no bus request; decoder sees registered bytes):
  - if need_opext && !ext_done -> FETCH_EXT
  - elif need_imm -> FETCH_IMM0
  - else -> ISSUE.
- FETCH_EXT: on ack, opext<=rdata, ext_done<=1, pc+1, len+1 -> EVAL (decoder re-evaluates with real opext).
- FETCH_IMM0: on ack, imm[7:0]<=rdata, pc+1, len+1. Then -> FETCH_IMM1 if imm_size, else -> ISSUE.
- FETCH_IMM1: on ack, imm[15:8]<=rdata, pc+1, len+1 -> ISSUE.
- ISSUE: instr_valid=1, all instr_* stable. On instr_ready -> FETCH_OP.
- Opcodes the decoder marks as neither prefix nor immediate (including undefined ones) issue as 1-byte instructions.
- pc arithmetic is 16-bit modulo; 16'hFFFF+1 = 16'h0000. Wrap inside a multi-byte instruction is legal.
- pc_load in any state except IDLE: pc<=pc_load_value, next state FETCH_OP. The bytes in flight are discarded, including an ack in that same cycle, and instr_valid drops next cycle.
- pc_load together with ISSUE&&instr_ready: the transfer counts (consumer took the instruction) and the redirect also applies.
- pc_load in IDLE: pc<=pc_load_value, then FETCH_OP.

## Timing
- bus_req, bus_addr and instr_valid are pure functions of registered state; there is no combinational path from any input to any output.
- Bus: a request may be withdrawn only on redirect. The bus accepts abandonment and never acks a withdrawn request.
- Zero-wait-state latency from FETCH_OP entry to instr_valid:
  - 1-byte: 2 cycles
  - opcode+imm8: 3 cycles
  - opcode+imm16: 4 cycles
  - prefix+opext: 4 cycles
  - prefix+opext+imm16: 6 cycles
- Each wait state on bus_ack adds exactly one cycle.
- Sustained throughput with instr_ready=1 and zero wait states: one 1-byte instruction per 3 cycles.
- First bus_req rises 1 cycle after reset deasserts. Reset asserted mid-fetch forces IDLE asynchronously and bus_req drops the same instant.

## Test plan
- Reset, RESET_PC=16'h2100, memory[2100]=8'hFF (1-byte): bus_req at cycle 1 with addr 2100; instr_valid at cycle 3 with opcode FF, len 1, instr_pc 2100, imm 0; pc=2101.
- Memory CE 05 44 from 0x0010 (prefix+opext+imm8): fetch addrs 0010, 0011, 0012; issue opcode CE, opext 05, imm 16'h0044, len 3; pc=0013.
- Memory CF 60 34 12 from 0x0200 with 2 wait states per read: issue opext 60, imm 16'h1234, len 4. instr_valid rises 6+4*2=14 cycles after FETCH_OP entry.
- Byte C0 at 16'hFFFF, followed by 78 56 at 0000/0001: issue imm 16'h5678, len 3, instr_pc FFFF; pc=0002.
- pc_load=1, value 16'h4000, asserted in FETCH_IMM0 in the same cycle as an ack: the acked byte is discarded, the next bus_addr is 4000, and no instruction issues from the old stream.
- ISSUE with instr_ready=0 held for 5 cycles: outputs stay stable and bus_req stays 0. Then ready=1 with pc_load=1 (0x0300) together: one transfer is counted and the next fetch is at 0300.
